// File: rtl/video_grabber.sv
// -----------------------------------------------------------------------------
// video_grabber
//
// Captures a burst of N 12-bit video samples into a local buffer on command,
// then serves them to the command encoder as a 2*N byte message (high nibble
// byte first, then low byte, per sample). Illegal counts (0 or > DEPTH) are
// answered with a single ERR_BYTE.
//
// Optional feature macro: VIDEO_GRAB_TRIG_EN
//   defined   : after command accept the block waits in ARM for a rising edge
//               of trig before capturing.
//   undefined : capture starts on the cycle after command accept; trig unused.
//
// Parameters
//   DEPTH     sample buffer depth, 1..127
//   ERR_BYTE  single-byte reply for an illegal sample count
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   data      command byte (requested sample count N), qualified by ena
//   ena       one-cycle command strobe
//   smp_stb   one-cycle sample-valid strobe
//   smp_data  12-bit video sample, valid with smp_stb
//   trig      capture trigger level (VIDEO_GRAB_TRIG_EN only)
//   have_msg  reply ready for the encoder
//   len       reply length in bytes, valid while have_msg=1
//   rdreq     encoder pop strobe, one byte per cycle
//   data_out  current reply byte (show-ahead)
//   busy      high in any state other than IDLE
// -----------------------------------------------------------------------------
module video_grabber #(
    parameter int          DEPTH    = 64,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        ena,
    input  logic        smp_stb,
    input  logic [11:0] smp_data,
    input  logic        trig,
    output logic        have_msg,
    output logic [7:0]  len,
    input  logic        rdreq,
    output logic [7:0]  data_out,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef VIDEO_GRAB_TRIG_EN
        S_ARM,
`endif
        S_CAPTURE,
        S_SEND,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [6:0]  n_q;
    logic [6:0]  wr_cnt_q;
    logic [7:0]  rd_cnt_q;
    logic        have_msg_q;
    logic [7:0]  len_q;
    logic [7:0]  data_out_q;

    logic [11:0] sbuf_q [DEPTH];

    logic [7:0]  rd_cnt_d;
    logic [11:0] nxt_word;
    logic [7:0]  nxt_byte;
    logic [3:0]  first_hi;
    logic        cmd_bad;

    // Sample buffer: contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (state_q == S_CAPTURE && smp_stb) begin
            sbuf_q[wr_cnt_q[AW-1:0]] <= smp_data;
        end
    end

`ifdef VIDEO_GRAB_TRIG_EN
    logic trig_q;
    logic trig_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
        end
    end

    assign trig_rise = trig & ~trig_q;
`else
    logic unused_trig;
    assign unused_trig = trig;
`endif

    always_comb begin
        cmd_bad  = (data == 8'd0) || (data > 8'(DEPTH));
        // Byte following the current one, pre-fetched so data_out stays
        // registered and can advance on every rdreq.
        rd_cnt_d = rd_cnt_q + 8'd1;
        nxt_word = sbuf_q[rd_cnt_d[AW:1]];
        nxt_byte = rd_cnt_d[0] ? nxt_word[7:0] : {4'h0, nxt_word[11:8]};
        // For N=1 the completing write targets buf[0] in the same cycle, so
        // byte 0 is forwarded straight from the incoming sample.
        first_hi = (wr_cnt_q == '0) ? smp_data[11:8] : sbuf_q[0][11:8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            have_msg_q <= 1'b0;
            len_q      <= '0;
            data_out_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ena) begin
                        if (cmd_bad) begin
                            state_q    <= S_ERR;
                            have_msg_q <= 1'b1;
                            len_q      <= 8'd1;
                            data_out_q <= ERR_BYTE;
                        end else begin
                            n_q      <= data[6:0];
                            wr_cnt_q <= '0;
`ifdef VIDEO_GRAB_TRIG_EN
                            state_q  <= S_ARM;
`else
                            state_q  <= S_CAPTURE;
`endif
                        end
                    end
                end

`ifdef VIDEO_GRAB_TRIG_EN
                S_ARM: begin
                    if (trig_rise) begin
                        state_q <= S_CAPTURE;
                    end
                end
`endif

                S_CAPTURE: begin
                    if (smp_stb) begin
                        wr_cnt_q <= wr_cnt_q + 7'd1;
                        if (wr_cnt_q + 7'd1 == n_q) begin
                            state_q    <= S_SEND;
                            have_msg_q <= 1'b1;
                            len_q      <= {n_q, 1'b0};
                            data_out_q <= {4'h0, first_hi};
                            rd_cnt_q   <= '0;
                        end
                    end
                end

                S_SEND: begin
                    if (rdreq) begin
                        if (rd_cnt_q == len_q - 8'd1) begin
                            state_q    <= S_IDLE;
                            have_msg_q <= 1'b0;
                            len_q      <= '0;
                            data_out_q <= '0;
                            rd_cnt_q   <= '0;
                        end else begin
                            rd_cnt_q   <= rd_cnt_d;
                            data_out_q <= nxt_byte;
                        end
                    end
                end

                S_ERR: begin
                    if (rdreq) begin
                        state_q    <= S_IDLE;
                        have_msg_q <= 1'b0;
                        len_q      <= '0;
                        data_out_q <= '0;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    have_msg_q <= 1'b0;
                    len_q      <= '0;
                    data_out_q <= '0;
                end
            endcase
        end
    end

    assign have_msg = have_msg_q;
    assign len      = len_q;
    assign data_out = data_out_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_video_grabber.sv
// -----------------------------------------------------------------------------
// tb_video_grabber
//
// Randomized self-checking bench for video_grabber. The reference model works
// at transaction level: it records which samples were strobed once a command
// is accepted, expands them into the expected byte message, and compares the
// encoder-side outputs as the message is drained.
// -----------------------------------------------------------------------------
module tb_video_grabber;

    localparam int         DEPTH    = 64;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        ena;
    logic        smp_stb;
    logic [11:0] smp_data;
    logic        trig;
    logic        have_msg;
    logic [7:0]  len;
    logic        rdreq;
    logic [7:0]  data_out;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [11:0] fixed_q [$];

    always #5 clk = ~clk;

    video_grabber #(
        .DEPTH    (DEPTH),
        .ERR_BYTE (ERR_BYTE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .ena      (ena),
        .smp_stb  (smp_stb),
        .smp_data (smp_data),
        .trig     (trig),
        .have_msg (have_msg),
        .len      (len),
        .rdreq    (rdreq),
        .data_out (data_out),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_have_msg"}, 32'(have_msg), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_len"},      32'(len),      32'd0);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
    endtask

    task automatic run_cmd(input int n);
        logic [11:0] samp  [$];
        logic [7:0]  exp_b [$];
        int          cyc;
        bit          legal;

        legal = (n >= 1) && (n <= DEPTH);

`ifdef VIDEO_GRAB_TRIG_EN
        trig = 1'b1;
`endif
        // A strobe in the accept cycle itself must never be captured.
        data     = 8'(n);
        ena      = 1'b1;
        smp_stb  = 1'($urandom_range(0, 1));
        smp_data = 12'($urandom);
        rdreq    = 1'b0;
        step();
        ena     = 1'b0;
        smp_stb = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);

        if (!legal) begin
            check("err_have_msg", 32'(have_msg), 32'd1);
            check("err_len",      32'(len),      32'd1);
            check("err_data_out", 32'(data_out), 32'(ERR_BYTE));
            repeat ($urandom_range(0, 3)) begin
                ena  = 1'b1;
                data = 8'($urandom_range(1, DEPTH));
                step();
                ena = 1'b0;
                check("err_hold_data", 32'(data_out), 32'(ERR_BYTE));
                check("err_hold_have", 32'(have_msg), 32'd1);
            end
            rdreq = 1'b1;
            step();
            rdreq = 1'b0;
            check_idle("err_release");
            return;
        end

`ifdef VIDEO_GRAB_TRIG_EN
        // Trig already high at accept: strobes are dropped until low-then-high.
        repeat ($urandom_range(1, 4)) begin
            smp_stb  = 1'b1;
            smp_data = 12'($urandom);
            step();
            smp_stb = 1'b0;
            check("arm_have_msg", 32'(have_msg), 32'd0);
        end
        trig = 1'b0;
        repeat ($urandom_range(1, 3)) begin
            smp_stb  = 1'b1;
            smp_data = 12'($urandom);
            step();
            smp_stb = 1'b0;
            check("arm_low_have_msg", 32'(have_msg), 32'd0);
        end
        // Edge cycle: this strobe is still dropped.
        trig     = 1'b1;
        smp_stb  = 1'b1;
        smp_data = 12'($urandom);
        step();
        smp_stb = 1'b0;
        check("arm_edge_busy", 32'(busy), 32'd1);
`endif

        cyc = 0;
        while (samp.size() < n) begin
            if (cyc > 4 * n + 200) begin
                check("capture_timeout", 32'd1, 32'd0);
                rst = 1'b1;
                step();
                rst = 1'b0;
                fixed_q.delete();
                return;
            end
            if (fixed_q.size() > 0) begin
                smp_stb  = 1'b1;
                smp_data = fixed_q[0];
            end else begin
                smp_stb  = ($urandom_range(0, 99) < 60);
                smp_data = 12'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                ena  = 1'b1;
                data = 8'd5;
            end
            rdreq = 1'($urandom_range(0, 1));
            step();
            if (smp_stb) begin
                samp.push_back(smp_data);
                if (fixed_q.size() > 0) void'(fixed_q.pop_front());
            end
            ena     = 1'b0;
            smp_stb = 1'b0;
            rdreq   = 1'b0;
            cyc++;
            check("cap_have_msg", 32'(have_msg), 32'(samp.size() == n));
            check("cap_busy",     32'(busy),     32'd1);
        end

        foreach (samp[i]) begin
            exp_b.push_back({4'h0, samp[i][11:8]});
            exp_b.push_back(samp[i][7:0]);
        end
        check("send_len", 32'(len), 32'(2 * n));

        foreach (exp_b[k]) begin
            // Stray strobes and commands while sending must change nothing.
            while ($urandom_range(0, 3) == 0) begin
                smp_stb  = 1'b1;
                smp_data = 12'($urandom);
                ena      = 1'b1;
                data     = 8'($urandom);
                step();
                smp_stb = 1'b0;
                ena     = 1'b0;
                check("send_hold", 32'(data_out), 32'(exp_b[k]));
            end
            check("send_byte",     32'(data_out), 32'(exp_b[k]));
            check("send_have_msg", 32'(have_msg), 32'd1);
            rdreq = 1'b1;
            step();
            rdreq = 1'b0;
        end
        check_idle("release");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        data     = '0;
        ena      = 1'b0;
        smp_stb  = 1'b0;
        smp_data = '0;
        trig     = 1'b0;
        rdreq    = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");

        // rdreq pulses in IDLE are ignored.
        repeat (3) begin
            rdreq = 1'b1;
            step();
            rdreq = 1'b0;
            check_idle("idle_rdreq");
        end

        // Basic capture: 0A BC 01 23 0F FF.
        fixed_q = '{12'hABC, 12'h123, 12'hFFF};
        run_cmd(3);

        // Illegal counts.
        run_cmd(0);
        run_cmd(DEPTH + 1);
        run_cmd(255);

        // N=2 with ena spam during capture and send.
        run_cmd(2);

        // Boundary: full buffer, sample value = index.
        for (int i = 0; i < DEPTH; i++) fixed_q.push_back(12'(i));
        run_cmd(DEPTH);
        run_cmd(1);

        // Reset mid-capture after 2 of 4 samples.
`ifdef VIDEO_GRAB_TRIG_EN
        trig = 1'b0;
`endif
        data = 8'd4;
        ena  = 1'b1;
        step();
        ena = 1'b0;
`ifdef VIDEO_GRAB_TRIG_EN
        trig = 1'b1;
        step();
`endif
        repeat (2) begin
            smp_stb  = 1'b1;
            smp_data = 12'($urandom);
            step();
            smp_stb = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_reset");
        fixed_q = '{12'h5A7};
        run_cmd(1);

        // Randomized commands, legal and illegal.
        repeat (30) begin
            run_cmd($urandom_range(0, DEPTH + 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
